operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Consumer/driver side of the 64-bit, 32-entry, 1-cycle synchronous-read register file.
- Accepts decoded instructions, drives the register-file read addresses and the write port, and returns source operands one cycle later.
- Tracks RAW/WAW hazards with a per-register busy scoreboard and forwards same-edge writes.
- Sits between decode and execute; all writeback traffic passes through it.

Parameters:
- XLEN, 64, register/operand width
- TAG_W, 32, width of the opaque instruction payload carried alongside operands
- CNT_W, 32, width of the stall counter

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  block can accept an instruction this cycle
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_rd  in  5  destination register (0 = no writeback)
- in_tag  in  TAG_W  payload
- rf_rs1  out  5  register-file read address 1
- rf_rs2  out  5  register-file read address 2
- rf_data1  in  XLEN  register-file read data 1 (registered, 1-cycle latency)
- rf_data2  in  XLEN  register-file read data 2
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- wb_valid  in  1  writeback from execute
- wb_rd  in  5  writeback register
- wb_data  in  XLEN  writeback data
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts operands
- out_op1  out  XLEN  operand 1
- out_op2  out  XLEN  operand 2
- out_rd  out  5  destination register
- out_tag  out  TAG_W  payload
- stall_cnt  out  CNT_W  cycles with in_valid && !in_ready

Behaviour:
- Reset (async):
  - f_valid=0, busy[31:0]=0, byp1/byp2=0, stall_cnt=0, held rs/rd/tag=0.
  - Outputs: out_valid=0, in_ready=1 (no hazard possible), out_op1/out_op2=0.
  - Reset mid-operation drops the held instruction; it is never presented.
- Single holding stage F (f_valid, f_rs1, f_rs2, f_rd, f_tag). out_valid=f_valid; out_rd=f_rd; out_tag=f_tag.
- Hazard (combinational): any nonzero register among in_rs1, in_rs2, in_rd that has its busy bit set, or equals f_rd while f_valid and f_rd!=0.
- in_ready = (!f_valid || out_ready) && !hazard. Accept = in_valid && in_ready.
- Read addressing: rf_rsN = accept ? in_rsN : f_rsN. Held addresses are re-read every cycle, so rf_dataN is always fresh for the held instruction.
- Write port (combinational pass-through): rf_we = wb_valid && wb_rd!=0; rf_rd=wb_rd; rf_wdata=wb_data.
- Same-edge forwarding: at each edge, bypN <= rf_we && rf_rd==rf_rsN, and bypdN <= wb_data. The register file returns the old value in this case.
- Operand mux: out_opN = (f_rsN==0) ? 0 : bypN ? bypdN : rf_dataN.
- Scoreboard:
  - On out_valid && out_ready with out_rd!=0, set busy[out_rd].
  - On wb_valid, clear busy[wb_rd].
  - Set and clear of the same register on the same edge: set wins.
  - busy[0] is never set.
  - wb to a non-busy register is legal: it is written, and busy is unchanged.
- Hazard uses pre-edge busy. An instruction reading a register being written back this cycle stalls one cycle, then is accepted and reads the committed value.
- Latency: accept at edge E gives out_valid=1 in the cycle after E. Full throughput is 1 instruction/cycle with no hazards.
- F update:
  - On accept, load F from the inputs.
  - Else if out_ready, clear f_valid.
  - Otherwise hold F.
- stall_cnt increments when in_valid && !in_ready. It saturates at all-ones.

Test Plan:
- Reset, then regfile x5=0x11, x6=0x22. Issue rs1=5, rs2=6, rd=7, tag=0xA. Next cycle: out_valid=1, op1=0x11, op2=0x22, out_rd=7, tag=0xA; after handshake busy[7]=1.
- Back-to-back: instr rd=7, then instr rs1=7. Second stalls (in_ready=0) until wb_valid rd=7 data=0x99, then one more cycle. Accepted next; op1=0x99; stall_cnt equals the stall cycles.
- Hold under backpressure: out_ready=0 for 3 cycles with rs1=9. Inject wb rd=9 data=0x55 (not busy) during the hold. op1 changes to 0x55 the cycle after the write; tag stable throughout.
- rs1=0, rs2=0, rd=0 with regfile garbage: op1=op2=0, and no busy bit is set.
- Simultaneous set and clear: out handshake rd=3 while wb_valid rd=3. Result busy[3]=1.
- Assert rst while out_valid=1 and busy[4]=1. Immediately out_valid=0, busy=0, stall_cnt=0. The dropped instruction is never seen after release.

Source files
------------

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage that drives a 1-cycle synchronous register file and owns its write port.
// Operands appear the cycle after accept. out_ready=0 holds the stage, and RAW/WAW hazards deassert in_ready.
module operand_fetch #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [4:0]       in_rd,
   input  logic [TAG_W-1:0] in_tag,
   output logic [4:0]       rf_rs1,
   output logic [4:0]       rf_rs2,
   input  logic [XLEN-1:0]  rf_data1,
   input  logic [XLEN-1:0]  rf_data2,
   output logic             rf_we,
   output logic [4:0]       rf_rd,
   output logic [XLEN-1:0]  rf_wdata,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_op1,
   output logic [XLEN-1:0]  out_op2,
   output logic [4:0]       out_rd,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic             vld;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [TAG_W-1:0] tag;
   } f_t;

   f_t               f_q, f_d;
   logic [31:0]      busy_q, busy_d;
   logic             byp1_q, byp1_d;
   logic             byp2_q, byp2_d;
   logic [XLEN-1:0]  bypd1_q, bypd1_d;
   logic [XLEN-1:0]  bypd2_q, bypd2_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             hazard;
   logic             accept;
   logic             out_fire;

   // A register conflicts if it is pending writeback or is the destination of the held instruction.
   function automatic logic reg_conflict(input logic [4:0] r, input logic [31:0] busy, input f_t f);
      return (r != 5'd0) && (busy[r] || (f.vld && (f.rd != 5'd0) && (f.rd == r)));
   endfunction

   always_comb begin
      hazard   = reg_conflict(in_rs1, busy_q, f_q) ||
                 reg_conflict(in_rs2, busy_q, f_q) ||
                 reg_conflict(in_rd,  busy_q, f_q);
      in_ready = (!f_q.vld || out_ready) && !hazard;
      accept   = in_valid && in_ready;
      out_fire = f_q.vld && out_ready;
   end

   // The held addresses are re-read every cycle so the operands track later writebacks.
   always_comb begin
      rf_rs1   = accept ? in_rs1 : f_q.rs1;
      rf_rs2   = accept ? in_rs2 : f_q.rs2;
      rf_we    = wb_valid && (wb_rd != 5'd0);
      rf_rd    = wb_rd;
      rf_wdata = wb_data;
   end

   always_comb begin
      f_d = f_q;
      if (accept) begin
         f_d.vld = 1'b1;
         f_d.rs1 = in_rs1;
         f_d.rs2 = in_rs2;
         f_d.rd  = in_rd;
         f_d.tag = in_tag;
      end else if (out_ready) begin
         f_d.vld = 1'b0;
      end

      // The register file returns the pre-write value when read and write collide on one edge.
      byp1_d  = rf_we && (rf_rd == rf_rs1);
      byp2_d  = rf_we && (rf_rd == rf_rs2);
      bypd1_d = wb_data;
      bypd2_d = wb_data;

      busy_d = busy_q;
      if (wb_valid)
         busy_d[wb_rd] = 1'b0;
      if (out_fire && (f_q.rd != 5'd0))
         busy_d[f_q.rd] = 1'b1;
      busy_d[0] = 1'b0;

      stall_cnt_d = stall_cnt_q;
      if (in_valid && !in_ready && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_q         <= '0;
         busy_q      <= '0;
         byp1_q      <= 1'b0;
         byp2_q      <= 1'b0;
         bypd1_q     <= '0;
         bypd2_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         f_q         <= f_d;
         busy_q      <= busy_d;
         byp1_q      <= byp1_d;
         byp2_q      <= byp2_d;
         bypd1_q     <= bypd1_d;
         bypd2_q     <= bypd2_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      out_valid = f_q.vld;
      out_rd    = f_q.rd;
      out_tag   = f_q.tag;
      out_op1   = (f_q.rs1 == 5'd0) ? '0 : (byp1_q ? bypd1_q : rf_data1);
      out_op2   = (f_q.rs2 == 5'd0) ? '0 : (byp2_q ? bypd2_q : rf_data2);
      stall_cnt = stall_cnt_q;
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a behavioural 1-cycle register file, an architectural shadow and an expected-result queue.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [31:0] in_tag;
   logic [4:0]  rf_rs1, rf_rs2, rf_rd;
   logic [63:0] rf_data1, rf_data2, rf_wdata;
   logic        rf_we;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        out_valid, out_ready;
   logic [63:0] out_op1, out_op2;
   logic [4:0]  out_rd;
   logic [31:0] out_tag;
   logic [31:0] stall_cnt;

   typedef struct packed {
      logic [63:0] op1;
      logic [63:0] op2;
      logic [4:0]  rd;
      logic [31:0] tag;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   logic [63:0] arch [32];
   logic [63:0] rf_mem [32];
   logic        rf_init;
   int          errors = 0;
   int          checks = 0;
   int          exp_stall = 0;

   operand_fetch dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_tag(in_tag),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_tag(out_tag),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pattern(input int i);
      return 64'hBAD0_0000_0000_0000 | 64'(i);
   endfunction

   // Register file: registered read data, read-before-write on a same-edge collision.
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= pattern(i);
      end else if (rf_we) begin
         rf_mem[rf_rd] <= rf_wdata;
      end
      rf_data1 <= rf_mem[rf_rs1];
      rf_data2 <= rf_mem[rf_rs2];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] val(input logic [4:0] r);
      return (r == 5'd0) ? 64'd0 : arch[r];
   endfunction

   task automatic drive_in(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d, input logic [31:0] t);
      in_valid = 1'b1; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_tag = t;
   endtask

   task automatic test_reset();
      rst = 1'b1; rf_init = 1'b1; in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0;
      in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_tag = '0; wb_rd = '0; wb_data = '0;
      tick();
      rf_init = 1'b0;
      for (int i = 0; i < 32; i++) arch[i] = pattern(i);
      tick();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++; $display("FAIL reset_ctl out_valid=%0b in_ready=%0b, want 0/1", out_valid, in_ready);
      end
      checks++;
      if ({out_op1, out_op2} !== 128'd0) begin
         errors++; $display("FAIL reset_ops op1=%h op2=%h, want 0", out_op1, out_op2);
      end
      checks++;
      if (stall_cnt !== 32'd0) begin
         errors++; $display("FAIL reset_stall stall_cnt=%0d, want 0", stall_cnt);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'h11;
      tick(); arch[5] = 64'h11;
      wb_rd = 5'd6; wb_data = 64'h22;
      tick(); arch[6] = 64'h22;
      wb_valid = 1'b0;
      drive_in(5'd5, 5'd6, 5'd7, 32'hA);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL basic_ready in_ready=%0b, want 1", in_ready);
      end
      exp_q.push_back('{op1: val(5), op2: val(6), rd: 5'd7, tag: 32'hA});
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL basic_valid out_valid=%0b queued=%0d, want 1", out_valid, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({out_op1, out_op2, out_rd, out_tag} !== e) begin
            errors++; $display("FAIL basic_data got %h %h rd=%0d tag=%h, want %h %h rd=%0d tag=%h",
                               out_op1, out_op2, out_rd, out_tag, e.op1, e.op2, e.rd, e.tag);
         end
      end
      tick();
      // x7 is now pending: a reader must stall even with the stage empty.
      drive_in(5'd7, 5'd0, 5'd0, 32'hAB);
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
         errors++; $display("FAIL basic_busy7 out_valid=%0b in_ready=%0b, want 0/0", out_valid, in_ready);
      end
      exp_stall++;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_raw_stall();
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h77;
      tick(); arch[7] = 64'h77;
      wb_valid = 1'b0;
      drive_in(5'd1, 5'd2, 5'd7, 32'hB1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL raw_first_ready in_ready=%0b, want 1", in_ready);
      end
      exp_q.push_back('{op1: val(1), op2: val(2), rd: 5'd7, tag: 32'hB1});
      tick();
      drive_in(5'd7, 5'd0, 5'd8, 32'hB2);
      #1;
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL raw_first_valid out_valid=%0b queued=%0d, want 1", out_valid, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({out_op1, out_op2, out_rd, out_tag} !== e) begin
            errors++; $display("FAIL raw_first_data got %h %h rd=%0d tag=%h, want %h %h rd=%0d tag=%h",
                               out_op1, out_op2, out_rd, out_tag, e.op1, e.op2, e.rd, e.tag);
         end
      end
      for (int c = 0; c < 5; c++) begin
         if (c == 4) begin
            wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h99;
         end
         #1;
         checks++;
         if (in_ready !== 1'b0) begin
            errors++; $display("FAIL raw_stall cycle %0d in_ready=%0b, want 0", c, in_ready);
         end
         exp_stall++;
         tick();
      end
      arch[7] = 64'h99;
      wb_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL raw_release in_ready=%0b, want 1", in_ready);
      end
      exp_q.push_back('{op1: val(7), op2: val(0), rd: 5'd8, tag: 32'hB2});
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL raw_second_valid out_valid=%0b queued=%0d, want 1", out_valid, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({out_op1, out_op2, out_rd, out_tag} !== e) begin
            errors++; $display("FAIL raw_second_data got %h %h rd=%0d tag=%h, want %h %h rd=%0d tag=%h",
                               out_op1, out_op2, out_rd, out_tag, e.op1, e.op2, e.rd, e.tag);
         end
      end
      checks++;
      if (stall_cnt !== 32'(exp_stall)) begin
         errors++; $display("FAIL raw_stall_cnt stall_cnt=%0d, want %0d", stall_cnt, exp_stall);
      end
      tick();
   endtask

   task automatic test_hold();
      drive_in(5'd9, 5'd1, 5'd10, 32'hC3);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL hold_ready in_ready=%0b, want 1", in_ready);
      end
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 0) begin
            wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h55;
         end
         if (c == 3) out_ready = 1'b1;
         #1;
         checks++;
         if ({out_valid, out_op1, out_op2, out_rd, out_tag} !==
             {1'b1, (c == 0) ? pattern(9) : 64'h55, val(1), 5'd10, 32'hC3}) begin
            errors++; $display("FAIL hold cycle %0d valid=%0b op1=%h op2=%h rd=%0d tag=%h, want op1=%h",
                               c, out_valid, out_op1, out_op2, out_rd, out_tag, (c == 0) ? pattern(9) : 64'h55);
         end
         tick();
         if (c == 0) begin
            arch[9] = 64'h55; wb_valid = 1'b0;
         end
      end
   endtask

   task automatic test_zero();
      for (int c = 0; c < 3; c++) begin
         if (c < 2) drive_in(5'd0, 5'd0, 5'd0, 32'hD0 + 32'(c));
         else in_valid = 1'b0;
         #1;
         if (c > 0) begin
            checks++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
               errors++; $display("FAIL zero_valid %0d out_valid=%0b, want 1", c, out_valid);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if ({out_op1, out_op2, out_rd, out_tag} !== e) begin
                  errors++; $display("FAIL zero_data got %h %h rd=%0d tag=%h, want 0 0 rd=0 tag=%h",
                                     out_op1, out_op2, out_rd, out_tag, e.tag);
               end
            end
         end
         if (c < 2) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++; $display("FAIL zero_ready %0d in_ready=%0b, want 1", c, in_ready);
            end
            exp_q.push_back('{op1: 64'd0, op2: 64'd0, rd: 5'd0, tag: 32'hD0 + 32'(c)});
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  s1 [4] = '{5'd1, 5'd3, 5'd5, 5'd2};
      logic [4:0]  s2 [4] = '{5'd2, 5'd4, 5'd6, 5'd5};
      logic [4:0]  ds [4] = '{5'd11, 5'd12, 5'd13, 5'd0};
      for (int c = 0; c < 5; c++) begin
         if (c < 4) drive_in(s1[c], s2[c], ds[c], 32'h100 + 32'(c));
         else in_valid = 1'b0;
         #1;
         if (c > 0) begin
            checks++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_valid %0d out_valid=%0b, want 1", c, out_valid);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if ({out_op1, out_op2, out_rd, out_tag} !== e) begin
                  errors++; $display("FAIL b2b_data %0d got %h %h rd=%0d tag=%h, want %h %h rd=%0d tag=%h",
                                     c, out_op1, out_op2, out_rd, out_tag, e.op1, e.op2, e.rd, e.tag);
               end
            end
         end
         if (c < 4) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++; $display("FAIL b2b_ready %0d in_ready=%0b, want 1", c, in_ready);
            end
            exp_q.push_back('{op1: val(s1[c]), op2: val(s2[c]), rd: ds[c], tag: 32'h100 + 32'(c)});
         end
         tick();
      end
   endtask

   task automatic test_set_clear();
      drive_in(5'd1, 5'd2, 5'd3, 32'hE1);
      exp_q.push_back('{op1: val(1), op2: val(2), rd: 5'd3, tag: 32'hE1});
      tick();
      in_valid = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h33;
      #1;
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL sc_valid out_valid=%0b, want 1", out_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({out_op1, out_op2, out_rd, out_tag} !== e) begin
            errors++; $display("FAIL sc_data got %h %h rd=%0d tag=%h, want %h %h rd=%0d tag=%h",
                               out_op1, out_op2, out_rd, out_tag, e.op1, e.op2, e.rd, e.tag);
         end
      end
      tick(); arch[3] = 64'h33;
      // Same-edge set and clear must leave x3 pending; the next writeback releases it.
      drive_in(5'd3, 5'd0, 5'd0, 32'hE2);
      wb_data = 64'h3C;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL sc_busy3 in_ready=%0b, want 0", in_ready);
      end
      exp_stall++;
      tick(); arch[3] = 64'h3C;
      wb_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL sc_release in_ready=%0b, want 1", in_ready);
      end
      exp_q.push_back('{op1: val(3), op2: 64'd0, rd: 5'd0, tag: 32'hE2});
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL sc_commit_valid out_valid=%0b, want 1", out_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({out_op1, out_rd, out_tag} !== {e.op1, e.rd, e.tag}) begin
            errors++; $display("FAIL sc_commit_data op1=%h tag=%h, want op1=%h tag=%h", out_op1, out_tag, e.op1, e.tag);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      drive_in(5'd0, 5'd0, 5'd4, 32'hF1);
      tick();
      drive_in(5'd1, 5'd0, 5'd14, 32'hF2);
      #1;
      checks++;
      if ({out_valid, out_tag, in_ready} !== {1'b1, 32'hF1, 1'b1}) begin
         errors++; $display("FAIL rm_setup valid=%0b tag=%h in_ready=%0b, want 1/F1/1", out_valid, out_tag, in_ready);
      end
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      in_rs1 = 5'd4; in_rs2 = 5'd0; in_rd = 5'd0;
      #1;
      checks++;
      if ({out_valid, out_tag} !== {1'b1, 32'hF2}) begin
         errors++; $display("FAIL rm_held valid=%0b tag=%h, want 1/F2", out_valid, out_tag);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, in_ready, stall_cnt, out_op1} !== {1'b0, 1'b1, 32'd0, 64'd0}) begin
         errors++; $display("FAIL rm_async valid=%0b in_ready=%0b stall_cnt=%0d op1=%h, want 0/1/0/0",
                            out_valid, in_ready, stall_cnt, out_op1);
      end
      tick(); tick();
      rst = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rm_dropped %0d out_valid=%0b tag=%h, want 0", c, out_valid, out_tag);
         end
         tick();
      end
      drive_in(5'd4, 5'd0, 5'd0, 32'hF3);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL rm_busy_cleared in_ready=%0b, want 1", in_ready);
      end
      exp_q.push_back('{op1: val(4), op2: 64'd0, rd: 5'd0, tag: 32'hF3});
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL rm_after_valid out_valid=%0b, want 1", out_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({out_op1, out_op2, out_rd, out_tag} !== e) begin
            errors++; $display("FAIL rm_after_data got %h %h rd=%0d tag=%h, want %h %h rd=%0d tag=%h",
                               out_op1, out_op2, out_rd, out_tag, e.op1, e.op2, e.rd, e.tag);
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_raw_stall();
      test_hold();
      test_zero();
      test_back_to_back();
      test_set_clear();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
